// File: rtl/pio_write_arbiter_if.sv
// rtl/pio_write_arbiter_if.sv - Request side and Avalon-MM PIO side signals of the PIO write arbiter
interface pio_write_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 32
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               m_chipselect;
   logic               m_write_n;
   logic [1:0]         m_address;
   logic [DW-1:0]      m_writedata;
   logic [2:0]         grant_id;
   logic [DW-1:0]      shadow_out;
   logic               busy;

   // master is the arbiter: it consumes requests and drives the PIO bus
   modport master (
      input  req_valid, req_data,
      output req_ready, m_chipselect, m_write_n, m_address, m_writedata,
             grant_id, shadow_out, busy
   );

   modport slave (
      output req_valid, req_data,
      input  req_ready, m_chipselect, m_write_n, m_address, m_writedata,
             grant_id, shadow_out, busy
   );
endinterface

// File: rtl/pio_write_arbiter.sv
// rtl/pio_write_arbiter.sv - Round-robin arbiter sharing one Avalon-MM PIO output register
// One bus write per grant, fixed idle gap after each write, unchanged values acked without a write.
module pio_write_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 32,
   parameter int MIN_GAP   = 2,
   parameter int SKIP_SAME = 1
) (
   input logic                 clk,
   input logic                 reset,
   pio_write_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, WRITE, GAP, ACK} state_t;

   localparam logic [3:0] GAP_LOAD = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;
   localparam logic [3:0] NREQ_W   = 4'(NREQ);
   localparam logic [2:0] LAST_ID  = 3'(NREQ - 1);

   state_t          state, state_d;
   logic [2:0]      ptr, ptr_d;
   logic [3:0]      gap_cnt, gap_cnt_d;
   logic [NREQ-1:0] ready, ready_d;
   logic            cs, cs_d;
   logic            wn, wn_d;
   logic [DW-1:0]   wdata, wdata_d;
   logic [2:0]      grant, grant_d;
   logic [DW-1:0]   shadow, shadow_d;
   logic            busy_r, busy_d;

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic              found;
   logic [2:0]        off;
   logic [3:0]        sum;
   logic [2:0]        win;
   logic [2:0]        win_next;
   logic [DW-1:0]     win_data;

   // Rotate the request vector so the pointer sits at bit 0; the lowest set bit wins.
   always_comb begin : arbitrate
      dbl   = {bus.req_valid, bus.req_valid} >> ptr;
      rot   = dbl[NREQ-1:0];
      found = 1'b0;
      off   = 3'd0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            off   = 3'(k);
         end
      end
      sum      = {1'b0, ptr} + {1'b0, off};
      win      = (sum >= NREQ_W) ? 3'(sum - NREQ_W) : sum[2:0];
      win_next = (win == LAST_ID) ? 3'd0 : win + 3'd1;
      win_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (win == 3'(k)) win_data = bus.req_data[k*DW +: DW];
      end
   end

   always_comb begin : fsm_next
      state_d   = state;
      ptr_d     = ptr;
      gap_cnt_d = gap_cnt;
      ready_d   = '0;
      cs_d      = 1'b0;
      wdata_d   = wdata;
      grant_d   = grant;
      shadow_d  = shadow;
      unique case (state)
         IDLE: begin
            if (found) begin
               ptr_d   = win_next;
               grant_d = win;
               ready_d = {{(NREQ-1){1'b0}}, 1'b1} << win;
               if (SKIP_SAME != 0 && win_data == shadow) begin
                  state_d = ACK;
               end else begin
                  state_d = WRITE;
                  cs_d    = 1'b1;
                  wdata_d = win_data;
               end
            end
         end
         WRITE: begin
            shadow_d = wdata;
            if (MIN_GAP > 0) begin
               state_d   = GAP;
               gap_cnt_d = GAP_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         GAP: begin
            if (gap_cnt == 4'd0) state_d = IDLE;
            else                 gap_cnt_d = gap_cnt - 4'd1;
         end
         ACK: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      wn_d   = ~cs_d;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= 3'd0;
         gap_cnt <= 4'd0;
         ready   <= '0;
         cs      <= 1'b0;
         wn      <= 1'b1;
         wdata   <= '0;
         grant   <= 3'd0;
         shadow  <= '0;
         busy_r  <= 1'b0;
      end else begin
         state   <= state_d;
         ptr     <= ptr_d;
         gap_cnt <= gap_cnt_d;
         ready   <= ready_d;
         cs      <= cs_d;
         wn      <= wn_d;
         wdata   <= wdata_d;
         grant   <= grant_d;
         shadow  <= shadow_d;
         busy_r  <= busy_d;
      end
   end

   assign bus.req_ready    = ready;
   assign bus.m_chipselect = cs;
   assign bus.m_write_n    = wn;
   assign bus.m_address    = 2'd0;
   assign bus.m_writedata  = wdata;
   assign bus.grant_id     = grant;
   assign bus.shadow_out   = shadow;
   assign bus.busy         = busy_r;
endmodule

// File: tb/tb_pio_write_arbiter.sv
// tb/tb_pio_write_arbiter.sv - Scoreboard bench for pio_write_arbiter
module tb_pio_write_arbiter;
   localparam int NREQ    = 4;
   localparam int DW      = 32;
   localparam int MIN_GAP = 2;

   typedef struct {
      int          id;
      logic [31:0] data;
      bit          skip;
   } exp_t;

   typedef struct {
      logic [3:0]       mask;
      logic [3:0][31:0] d;
      int               exp_writes;
      int               exp_acks;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;

   exp_t        exp_q[$];
   int          m_ptr;
   logic [31:0] m_shadow;
   logic [31:0] exp_shadow;
   int          strobes = 0;
   int          acks = 0;
   int          last_strobe = -1;
   int          skip_cyc = 0;
   bit          mon_en = 0;
   bit          hold_mode = 0;
   bit          spacing_chk = 0;
   bit          skip_gap_chk = 0;
   int          hold_limit = 0;
   vec_t        tbl[6];

   pio_write_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

   pio_write_arbiter #(
      .NREQ(NREQ), .DW(DW), .MIN_GAP(MIN_GAP), .SKIP_SAME(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic model_reset();
      m_ptr      = 0;
      m_shadow   = '0;
      exp_shadow = '0;
      exp_q.delete();
      last_strobe = -1;
   endtask

   task automatic push_exp(input int id, input logic [31:0] data);
      exp_t e;
      e.id   = id;
      e.data = data;
      e.skip = (data == m_shadow);
      if (!e.skip) m_shadow = data;
      m_ptr = (id + 1) % NREQ;
      exp_q.push_back(e);
   endtask

   task automatic push_vector(input logic [3:0] mask, input logic [3:0][31:0] d);
      logic [3:0] pend;
      pend = mask;
      for (int n = 0; n < NREQ; n++) begin
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (pend[i]) begin
               pend[i] = 1'b0;
               push_exp(i, d[i]);
               break;
            end
         end
      end
   endtask

   // One clock of monitoring, sampled on the falling edge.
   task automatic step();
      logic  strobe;
      int    id;
      exp_t  e;
      @(negedge clk);
      if (!mon_en) return;
      strobe = bus.m_chipselect && !bus.m_write_n;
      if (bus.req_ready != '0) begin
         acks++;
         chk("ready_onehot", $countones(bus.req_ready), 1);
         id = 0;
         for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) id = i;
         if (exp_q.size() == 0) begin
            fail("unexpected_ack", 32'(bus.req_ready), 0);
         end else begin
            e = exp_q.pop_front();
            chk("ack_id", id, e.id);
            chk("grant_id", 32'(bus.grant_id), e.id);
            if (e.skip) begin
               chk("skip_no_strobe", 32'(strobe), 0);
               skip_cyc = cyc;
            end else begin
               chk("strobe_with_ready", 32'(strobe), 1);
               chk("writedata", bus.m_writedata, e.data);
               chk("address", 32'(bus.m_address), 0);
               chk("shadow_before", bus.shadow_out, exp_shadow);
               exp_shadow = e.data;
            end
         end
         if (!hold_mode) bus.req_valid[id] = 1'b0;
         else if (acks >= hold_limit) bus.req_valid = '0;
      end else if (strobe) begin
         fail("strobe_without_ready", bus.m_writedata, 0);
      end
      if (strobe) begin
         strobes++;
         if (spacing_chk && last_strobe >= 0) chk("strobe_spacing", cyc - last_strobe, MIN_GAP + 2);
         last_strobe = cyc;
         if (skip_gap_chk) begin
            chk("skip_to_strobe", cyc - skip_cyc, 2);
            skip_gap_chk = 0;
         end
      end
   endtask

   task automatic wait_idle(input int budget);
      bit done;
      int n;
      done = 0;
      n = 0;
      while (!done && n < budget) begin
         step();
         n++;
         done = (exp_q.size() == 0) && (bus.busy == 1'b0) && (bus.req_valid == '0);
      end
      if (!done) fail("idle_timeout", n, budget);
      chk("idle_chipselect", 32'(bus.m_chipselect), 0);
      chk("shadow_final", bus.shadow_out, exp_shadow);
   endtask

   task automatic apply_reset();
      mon_en = 0;
      reset  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      mon_en = 1;
   endtask

   task automatic set_vec(input int v, input logic [3:0] mask, input logic [31:0] d3,
                          input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
                          input int w, input int a);
      tbl[v].mask       = mask;
      tbl[v].d          = {d3, d2, d1, d0};
      tbl[v].exp_writes = w;
      tbl[v].exp_acks   = a;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got %0d cycles expected completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      int n;
      bus.req_valid = '0;
      bus.req_data  = '0;
      model_reset();

      // Reset values while reset is held
      @(negedge clk);
      chk("rst_chipselect", 32'(bus.m_chipselect), 0);
      chk("rst_write_n", 32'(bus.m_write_n), 1);
      chk("rst_address", 32'(bus.m_address), 0);
      chk("rst_writedata", bus.m_writedata, 0);
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_grant", 32'(bus.grant_id), 0);
      chk("rst_shadow", bus.shadow_out, 0);
      chk("rst_busy", 32'(bus.busy), 0);
      reset  = 1'b0;
      mon_en = 1;
      repeat (10) step();
      chk("quiet_strobes", strobes, 0);
      chk("quiet_busy", 32'(bus.busy), 0);

      // Table: arbitration order comes from the model, counts are hand-derived
      set_vec(0, 4'b0001, 32'h0, 32'h0, 32'h0, 32'hA5A5_0001, 1, 1);
      set_vec(1, 4'b1111, 32'h44, 32'h33, 32'h22, 32'h11, 4, 4);
      set_vec(2, 4'b0101, 32'h0, 32'hABCD, 32'h0, 32'hABCD, 1, 2);
      set_vec(3, 4'b1000, 32'hABCD, 32'h0, 32'h0, 32'h0, 0, 1);
      set_vec(4, 4'b1010, 32'h6, 32'h0, 32'h5, 32'h0, 2, 2);
      set_vec(5, 4'b0011, 32'h0, 32'h0, 32'h6, 32'h6, 0, 2);
      for (int v = 0; v < 6; v++) begin
         int s0;
         s0 = strobes;
         a0 = acks;
         for (int i = 0; i < NREQ; i++) bus.req_data[i*32 +: 32] = tbl[v].d[i];
         push_vector(tbl[v].mask, tbl[v].d);
         bus.req_valid = tbl[v].mask;
         wait_idle(200);
         chk($sformatf("vec%0d_writes", v), strobes - s0, tbl[v].exp_writes);
         chk($sformatf("vec%0d_acks", v), acks - a0, tbl[v].exp_acks);
      end

      // All requesters held valid: order 0,1,2,3,0 at MIN_GAP+2 spacing
      apply_reset();
      for (int i = 0; i < NREQ; i++) bus.req_data[i*32 +: 32] = 32'hC0DE_0000 + i;
      for (int i = 0; i < 5; i++) push_exp(i % NREQ, 32'hC0DE_0000 + (i % NREQ));
      hold_mode   = 1;
      hold_limit  = acks + 5;
      spacing_chk = 1;
      bus.req_valid = 4'b1111;
      wait_idle(300);
      hold_mode   = 0;
      spacing_chk = 0;

      // Unchanged value is acked without a strobe; next write two cycles after the ack
      bus.req_data[0 +: 32] = 32'h0000_00FF;
      push_exp(0, 32'h0000_00FF);
      bus.req_valid = 4'b0001;
      wait_idle(100);
      bus.req_data[32 +: 32] = 32'h0000_00FF;
      bus.req_data[64 +: 32] = 32'h0000_0001;
      push_exp(1, 32'h0000_00FF);
      push_exp(2, 32'h0000_0001);
      skip_gap_chk = 1;
      bus.req_valid = 4'b0110;
      wait_idle(100);
      chk("skip_gap_seen", 32'(skip_gap_chk), 0);

      // Reset asserted in the middle of a WRITE cycle
      apply_reset();
      bus.req_data[32 +: 32] = 32'h0000_AAAA;
      push_exp(1, 32'h0000_AAAA);
      bus.req_valid = 4'b0010;
      wait_idle(100);
      mon_en = 0;
      bus.req_data[0 +: 32] = 32'h1234_5678;
      bus.req_valid = 4'b0001;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.m_chipselect && n < 20);
      chk("midwrite_reached", 32'(bus.m_chipselect), 1);
      #2 reset = 1'b1;
      #1;
      chk("async_chipselect", 32'(bus.m_chipselect), 0);
      chk("async_write_n", 32'(bus.m_write_n), 1);
      chk("async_shadow", bus.shadow_out, 0);
      chk("async_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      bus.req_data[64 +: 32] = 32'h0000_BEEF;
      bus.req_valid = 4'b0101;
      push_exp(0, 32'h1234_5678);
      push_exp(2, 32'h0000_BEEF);
      mon_en = 1;
      wait_idle(100);

      // Requester 3 withdraws during the gap after a requester 0 write
      bus.req_data[0 +: 32] = 32'h600D_0000;
      push_exp(0, 32'h600D_0000);
      bus.req_valid = 4'b0001;
      a0 = acks;
      n = 0;
      while (acks == a0 && n < 50) begin
         step();
         n++;
      end
      chk("abort_req0_acked", acks - a0, 1);
      bus.req_data[96 +: 32] = 32'h0000_DEAD;
      bus.req_valid[3] = 1'b1;
      step();
      bus.req_valid[3] = 1'b0;
      bus.req_data[32 +: 32] = 32'h0000_1111;
      bus.req_valid[1] = 1'b1;
      push_exp(1, 32'h0000_1111);
      wait_idle(100);
      chk("abort_total_acks", acks - a0, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
